// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous level: synchroniser chain, four-state stability FSM
// with a dwell counter, and a saturating counter of aborted candidates.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       noisy_in,
  input  logic       clr_glitch,
  output logic       level_out,
  output logic       busy,
  output logic       glitch,
  output logic [7:0] glitch_cnt,
  output logic [1:0] dbg_state
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   level_nxt;
  logic                   glitch_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  // Plain flop chain; only the last stage is ever looked at.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_LOW;
      cnt       <= '0;
      level_out <= 1'b0;
      glitch    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      level_out <= level_nxt;
      glitch    <= glitch_nxt;
    end
  end

  // The terminal compare is tested before the increment, so cnt never wraps.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    level_nxt  = level_out;
    glitch_nxt = 1'b0;
    case (state)
      ST_LOW: begin
        if (sync) begin
          state_nxt = ST_WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!sync) begin
          state_nxt  = ST_LOW;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HIGH;
          level_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!sync) begin
          state_nxt = ST_WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (sync) begin
          state_nxt  = ST_HIGH;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LOW;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_LOW;
      end
    endcase
  end

  // A clear in the same cycle as a glitch pulse takes priority over the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_cnt <= 8'd0;
    end else if (clr_glitch) begin
      glitch_cnt <= 8'd0;
    end else if (glitch && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end

  assign busy      = (state == ST_WAIT_HIGH) || (state == ST_WAIT_LOW);
  assign dbg_state = state;

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions a raw asynchronous level input, such as a push-button or an external strobe, into a clean, glitch-free, clock-synchronous level. It sits directly upstream of the edge-detection stage, which consumes `level_out` as its `level` input. The block has three parts:
- a synchroniser chain;
- a four-state stability FSM with a dwell counter;
- a saturating glitch counter for diagnostics.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchroniser flops. Legal values are ≥ 2.
- `DEBOUNCE_CYCLES`, default 1000: number of consecutive stable synchronised samples required to accept a change. Legal values are ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)` with a minimum of 1: width of the dwell counter. This is a derived value and must not be overridden.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `noisy_in`, in, 1: raw asynchronous input.
- `clr_glitch`, in, 1: synchronous clear of `glitch_cnt`.
- `level_out`, out, 1: debounced level.
- `busy`, out, 1: high while a candidate change is being qualified.
- `glitch`, out, 1: one-cycle pulse when a candidate change is aborted.
- `glitch_cnt`, out, 8: number of aborted candidates, saturating at 255.

## Operation
- **Synchroniser:** `noisy_in` passes through `SYNC_STAGES` flops. The last stage output is `sync`. No logic sits between the stages.
- **FSM states:** LOW, WAIT_HIGH, HIGH, WAIT_LOW. The dwell counter `cnt` is `CNT_W` bits wide.
- **LOW:**
  - `sync`=1: go to WAIT_HIGH and set `cnt` to 0.
  - Otherwise: stay in LOW.
- **WAIT_HIGH:**
  - `sync`=0: go to LOW and pulse `glitch`.
  - Else, `cnt` == `DEBOUNCE_CYCLES`-1: go to HIGH.
  - Else: increment `cnt`.
- **HIGH and WAIT_LOW:** mirror LOW and WAIT_HIGH with the polarity of `sync` inverted.
- **Outputs:**
  - `level_out` is a registered output. It is set on entry to HIGH and cleared on entry to LOW.
  - It holds its previous value throughout both WAIT states.
- `busy` = (state == WAIT_HIGH) or (state == WAIT_LOW). It is decoded from registered state only.
- `glitch` is registered and asserted for exactly one cycle per aborted candidate.
- **`glitch_cnt`:**
  - Increments on each cycle where `glitch` is set and saturates at 255.
  - `clr_glitch` forces it to 0 on the next edge.
  - If `clr_glitch` and a glitch occur in the same cycle, the clear wins and the count becomes 0.
  - The `glitch` pulse itself still fires.
- **Reset:**
  - `reset_n` low clears the synchroniser, `cnt`, `glitch`, `glitch_cnt` and `level_out` to 0, and forces state to LOW, immediately and asynchronously.
  - A reset asserted mid-qualification discards the candidate; this does not count as a glitch.
  - If the input is held high across reset release, the block re-qualifies it with full latency.
- **`DEBOUNCE_CYCLES` = 1:** the WAIT state lasts exactly one cycle. The transition still requires `sync` to remain stable on that cycle.
- **Counter overflow:** `cnt` never wraps, because the terminal compare precedes the increment.

## Timing
- **Accepted change:** `noisy_in` changes and is stable before clock edge 1. Then:
  - `sync` updates after edge `SYNC_STAGES`.
  - The WAIT state is entered after edge `SYNC_STAGES`+1.
  - `level_out` updates after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1.
  - Total latency is `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1 cycles; with the defaults this is 1003.
- **`busy`:** high for exactly `DEBOUNCE_CYCLES` cycles for an accepted change. It is low in the same cycle that `level_out` changes.
- **Aborted candidate:** `glitch` pulses in the cycle after `sync` reverts. `busy` falls in that same cycle, and `glitch_cnt` updates one cycle after the `glitch` edge.
- **Minimum pulse width:** a `noisy_in` pulse shorter than `DEBOUNCE_CYCLES`+1 cycles never changes `level_out`.
- **Throughput:** after an accepted change, the FSM may begin qualifying the opposite transition on the very next cycle.

## Test plan
- **Reset values:** assert `reset_n`=0 mid-simulation with `noisy_in`=1. Required:
  - `level_out`=0, `busy`=0, `glitch`=0, `glitch_cnt`=0 immediately, without waiting for a clock edge.
  - After release, `level_out` rises exactly `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1 cycles later.
- **Clean edges:** set `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4. Apply a 0→1 step and hold it, then a 1→0 step and hold it. Required:
  - `level_out` rises 7 cycles after the step and falls 7 cycles after the falling step.
  - `busy` is high for exactly 4 cycles in each qualification.
- **Bounce:** with `DEBOUNCE_CYCLES`=4, apply high pulses of 1, 2 and 3 cycles, each separated by 6 low cycles. Required:
  - `level_out` stays 0 throughout.
  - Three `glitch` pulses occur and `glitch_cnt` reads 3.
- **Saturation and clear:** generate 260 aborted candidates. Required:
  - `glitch_cnt` reads 255 and holds there.
  - Pulsing `clr_glitch` coincident with a further glitch gives `glitch_cnt`=0, and `glitch` still pulses.
- **Reset mid-qualification:** with `DEBOUNCE_CYCLES`=4, assert `reset_n` low 2 cycles into WAIT_HIGH. Required:
  - `busy` drops to 0 immediately and `glitch_cnt` is unchanged at 0.
  - `level_out` rises a full 7 cycles after reset release.
- **`DEBOUNCE_CYCLES`=1:** apply a 2-cycle high pulse on `noisy_in`. Required: `level_out` is high for 2 cycles, starting 4 cycles after the pulse starts.
